layer2_sequencer: RTL and testbench

//  Drives one layer2_neuron through all Layer-2 output neurons, one neuron at a time.
//  Per neuron: serves input_val/weight/bias to the neuron, indexed by its mac_count_out.

---
 rtl/layer2_pkg.sv | 20 ++
 rtl/layer2_sequencer_argmax_tracker.sv | 45 ++++
 rtl/layer2_sequencer.sv | 143 ++++++++++++++
 tb/tb_layer2_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer2_pkg.sv
// Shared definitions for the Layer-2 sequencer: ternary codes, sizes, FSM states.
package layer2_pkg;

    localparam int L2_NUM_IN  = 48;
    localparam int L2_NUM_OUT = 10;
    localparam int L2_WA_W    = 9;
    localparam int LOGIT_W    = 6;

    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_RELEASE = 2'd2,
        S_FINISH  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/layer2_sequencer_argmax_tracker.sv
// Running argmax over the logits as they arrive; ties keep the lowest class index.
module argmax_tracker
    import layer2_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      load,
    input  logic [3:0]                idx,
    input  logic signed [LOGIT_W-1:0] value,
    output logic [3:0]                class_idx,
    output logic signed [LOGIT_W-1:0] class_score
);

    logic [3:0]                class_idx_q,   class_idx_d;
    logic signed [LOGIT_W-1:0] class_score_q, class_score_d;

    // Class 0 seeds the search; later classes win only when strictly greater.
    always_comb begin
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;
        if (clear) begin
            class_idx_d   = '0;
            class_score_d = '0;
        end else if (load && ((idx == 4'd0) || (value > class_score_q))) begin
            class_idx_d   = idx;
            class_score_d = value;
        end
    end

    // Argmax state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            class_idx_q   <= '0;
            class_score_q <= '0;
        end else begin
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
        end
    end

    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;

endmodule

// File: rtl/layer2_sequencer.sv
// Steps one shared Layer-2 neuron through every output class, serving its operands
// combinationally from its own MAC index and collecting logits plus the argmax.
module layer2_sequencer
    import layer2_pkg::*;
#(
    parameter int NUM_IN  = L2_NUM_IN,
    parameter int NUM_OUT = L2_NUM_OUT,
    parameter int WA_W    = L2_WA_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    input  logic [NUM_IN-1:0]            act_bits,
    output logic [WA_W-1:0]              w_addr,
    input  logic [1:0]                   w_data,
    output logic [3:0]                   b_addr,
    input  logic [3:0]                   b_data,
    output logic                         neu_start,
    output logic [1:0]                   neu_input,
    output logic [1:0]                   neu_weight,
    output logic [3:0]                   neu_bias,
    input  logic                         neu_done,
    input  logic [LOGIT_W-1:0]           neu_result,
    input  logic [5:0]                   neu_mac_cnt,
    output logic                         busy,
    output logic                         valid,
    output logic [LOGIT_W*NUM_OUT-1:0]   logits,
    output logic [3:0]                   class_idx,
    output logic [LOGIT_W-1:0]           class_score
);

    localparam logic [WA_W-1:0] NUM_IN_W   = WA_W'(NUM_IN);
    localparam logic [5:0]      NUM_IN_C   = 6'(NUM_IN);
    localparam logic [3:0]      LAST_CLASS = 4'(NUM_OUT - 1);

    seq_state_e                  state_q, state_d;
    logic [NUM_IN-1:0]           act_q, act_d;
    logic [3:0]                  cls_q, cls_d;
    logic [LOGIT_W*NUM_OUT-1:0]  logits_q, logits_d;
    logic                        argmax_clear;
    logic                        argmax_load;
    logic                        active;

    // Next-state and control: run is only honoured from idle, so a busy run is never restarted.
    always_comb begin
        state_d      = state_q;
        act_d        = act_q;
        cls_d        = cls_q;
        logits_d     = logits_q;
        neu_start    = 1'b0;
        busy         = 1'b0;
        valid        = 1'b0;
        argmax_clear = 1'b0;
        argmax_load  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    act_d        = act_bits;
                    cls_d        = '0;
                    logits_d     = '0;
                    argmax_clear = 1'b1;
                    state_d      = S_START;
                end
            end
            S_START: begin
                busy      = 1'b1;
                neu_start = 1'b1;
                if (neu_done) begin
                    logits_d[LOGIT_W*int'(cls_q) +: LOGIT_W] = neu_result;
                    argmax_load = 1'b1;
                    state_d     = S_RELEASE;
                end
            end
            S_RELEASE: begin
                busy = 1'b1;
                if (!neu_done) begin
                    if (cls_q == LAST_CLASS) begin
                        state_d = S_FINISH;
                    end else begin
                        cls_d   = cls_q + 4'd1;
                        state_d = S_START;
                    end
                end
            end
            S_FINISH: begin
                valid   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state, latched activations, class counter and logit store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            act_q    <= '0;
            cls_q    <= '0;
            logits_q <= '0;
        end else begin
            state_q  <= state_d;
            act_q    <= act_d;
            cls_q    <= cls_d;
            logits_q <= logits_d;
        end
    end

    // Operand path follows the neuron's MAC index with zero latency; idle outputs stay at 0.
    always_comb begin
        active     = (state_q == S_START) || (state_q == S_RELEASE);
        w_addr     = '0;
        b_addr     = '0;
        neu_bias   = '0;
        neu_input  = W_ZERO;
        neu_weight = W_ZERO;
        if (active) begin
            w_addr   = WA_W'(cls_q) * NUM_IN_W + WA_W'(neu_mac_cnt);
            b_addr   = cls_q;
            neu_bias = b_data;
            if (neu_mac_cnt < NUM_IN_C) begin
                neu_input  = act_q[neu_mac_cnt] ? W_POS : W_NEG;
                neu_weight = w_data;
            end else begin
                neu_input  = W_POS;
                neu_weight = W_ZERO;
            end
        end
    end

    argmax_tracker u_argmax (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (argmax_clear),
        .load        (argmax_load),
        .idx         (cls_q),
        .value       (neu_result),
        .class_idx   (class_idx),
        .class_score (class_score)
    );

    assign logits = logits_q;

endmodule

// File: tb/tb_layer2_sequencer.sv
// Bench for layer2_sequencer: behavioural neuron and ROMs, directed scenarios,
// expected results queued at stimulus time and compared by a monitor on each valid.
module tb_layer2_sequencer;

    localparam int NUM_IN  = 48;
    localparam int NUM_OUT = 10;
    localparam int WA_W    = 9;
    localparam int LAT_MAX = NUM_OUT * 53 + 2;

    logic                clk;
    logic                rst_n;
    logic                run;
    logic [NUM_IN-1:0]   act_bits;
    logic [WA_W-1:0]     w_addr;
    logic [1:0]          w_data;
    logic [3:0]          b_addr;
    logic [3:0]          b_data;
    logic                neu_start;
    logic [1:0]          neu_input;
    logic [1:0]          neu_weight;
    logic [3:0]          neu_bias;
    logic                neu_done;
    logic [5:0]          neu_result;
    logic [5:0]          neu_mac_cnt;
    logic                busy;
    logic                valid;
    logic [6*NUM_OUT-1:0] logits;
    logic [3:0]          class_idx;
    logic [5:0]          class_score;

    logic [1:0] wrom [0:(1<<WA_W)-1];
    logic [3:0] brom [0:15];

    typedef struct {
        string               name;
        logic [6*NUM_OUT-1:0] logits;
        logic [3:0]          idx;
        logic [5:0]          score;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks;
    int   n_pass;
    int   valid_count;

    layer2_sequencer #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .WA_W(WA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .act_bits    (act_bits),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .neu_start   (neu_start),
        .neu_input   (neu_input),
        .neu_weight  (neu_weight),
        .neu_bias    (neu_bias),
        .neu_done    (neu_done),
        .neu_result  (neu_result),
        .neu_mac_cnt (neu_mac_cnt),
        .busy        (busy),
        .valid       (valid),
        .logits      (logits),
        .class_idx   (class_idx),
        .class_score (class_score)
    );

    assign w_data = wrom[w_addr];
    assign b_data = brom[b_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural neuron: bias preload, MAC over indices 0..48, done held until start drops.
    int   acc;
    logic nrun;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nrun        <= 1'b0;
            neu_done    <= 1'b0;
            neu_mac_cnt <= '0;
            acc         <= 0;
        end else if (neu_done) begin
            if (!neu_start) begin
                neu_done    <= 1'b0;
                neu_mac_cnt <= '0;
            end
        end else if (!nrun) begin
            if (neu_start) begin
                nrun        <= 1'b1;
                neu_mac_cnt <= '0;
                acc         <= int'($signed(neu_bias));
            end
        end else begin
            acc <= acc + int'($signed(neu_input)) * int'($signed(neu_weight));
            if (neu_mac_cnt == 6'd48) begin
                nrun     <= 1'b0;
                neu_done <= 1'b1;
            end else begin
                neu_mac_cnt <= neu_mac_cnt + 6'd1;
            end
        end
    end
    assign neu_result = acc[5:0];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every valid pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            valid_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_valid", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput({mon_e.name, "_logits"}, 64'(logits), 64'(mon_e.logits));
                checkOutput({mon_e.name, "_class_idx"}, 64'(class_idx), 64'(mon_e.idx));
                checkOutput({mon_e.name, "_class_score"}, 64'(class_score), 64'(mon_e.score));
            end
        end
    end

    task automatic applyReset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic clearRoms(input logic [3:0] bias);
        for (int i = 0; i < (1 << WA_W); i++) wrom[i] = 2'b00;
        for (int i = 0; i < 16; i++) brom[i] = bias;
    endtask

    task automatic romScenario1();
        clearRoms(4'd0);
        for (int i = 0; i < 20; i++) wrom[7*NUM_IN + i] = 2'b01;
        brom[7] = 4'd2;
    endtask

    task automatic pushExpect(input string name, input logic [6*NUM_OUT-1:0] l,
                              input logic [3:0] idx, input logic [5:0] score);
        exp_t e;
        e.name   = name;
        e.logits = l;
        e.idx    = idx;
        e.score  = score;
        exp_q.push_back(e);
    endtask

    // Accepted on the next rising edge; afterwards act_bits is inverted to show it is no longer used.
    task automatic startRun(input logic [NUM_IN-1:0] acts);
        @(posedge clk);
        #1;
        act_bits = acts;
        run      = 1'b1;
        @(posedge clk);
        #1;
        run      = 1'b0;
        act_bits = ~acts;
    endtask

    task automatic waitValid(input string name, input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (valid) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({name, "_valid_in_time"}, 64'(seen), 64'd1);
    endtask

    task automatic applyStimulus(input string name, input logic [NUM_IN-1:0] acts,
                                 input logic [6*NUM_OUT-1:0] l, input logic [3:0] idx,
                                 input logic [5:0] score);
        pushExpect(name, l, idx, score);
        startRun(acts);
        waitValid(name, LAT_MAX);
        @(negedge clk);
        checkOutput({name, "_busy_after"}, 64'(busy), 64'd0);
        checkOutput({name, "_valid_one_cycle"}, 64'(valid), 64'd0);
    endtask

    logic [6*NUM_OUT-1:0] l_exp;
    int                   vc_before;

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        valid_count = 0;
        run         = 1'b0;
        act_bits    = '0;
        clearRoms(4'd0);
        applyReset();

        // Reset state.
        @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_valid", 64'(valid), 64'd0);
        checkOutput("reset_neu_start", 64'(neu_start), 64'd0);
        checkOutput("reset_logits", 64'(logits), 64'd0);
        checkOutput("reset_class_idx", 64'(class_idx), 64'd0);
        checkOutput("reset_class_score", 64'(class_score), 64'd0);
        checkOutput("reset_w_addr", 64'(w_addr), 64'd0);
        checkOutput("reset_neu_input", 64'(neu_input), 64'd0);

        // 1: class 7 sees twenty +1 products plus bias 2.
        romScenario1();
        l_exp = '0;
        l_exp[6*7 +: 6] = 6'd22;
        applyStimulus("s1", {NUM_IN{1'b1}}, l_exp, 4'd7, 6'd22);

        // 2: all -1 activations; class 2 has ten -1 weights and bias -3, others bias -1.
        clearRoms(4'hF);
        for (int i = 0; i < 10; i++) wrom[2*NUM_IN + i] = 2'b11;
        brom[2] = 4'hD;
        l_exp = {NUM_OUT{6'h3F}};
        l_exp[6*2 +: 6] = 6'd7;
        applyStimulus("s2", {NUM_IN{1'b0}}, l_exp, 4'd2, 6'd7);

        // 3: every logit equals the bias 1, tie resolves to class 0.
        clearRoms(4'd1);
        applyStimulus("s3", 48'hA5A5_5A5A_C3C3, {NUM_OUT{6'd1}}, 4'd0, 6'd1);

        // 4: 48 passes through as -16 in six bits; class 1 at +1 wins.
        clearRoms(4'd0);
        for (int i = 0; i < NUM_IN; i++) wrom[i] = 2'b01;
        brom[1] = 4'd1;
        l_exp = '0;
        l_exp[0 +: 6] = 6'h30;
        l_exp[6 +: 6] = 6'd1;
        applyStimulus("s4", {NUM_IN{1'b1}}, l_exp, 4'd1, 6'd1);

        // 5: a second run pulse mid-inference must neither restart nor relatch.
        romScenario1();
        l_exp = '0;
        l_exp[6*7 +: 6] = 6'd22;
        vc_before = valid_count;
        pushExpect("s5", l_exp, 4'd7, 6'd22);
        startRun({NUM_IN{1'b1}});
        repeat (150) @(posedge clk);
        #1;
        act_bits = '0;
        run      = 1'b1;
        @(posedge clk);
        #1;
        run      = 1'b0;
        checkOutput("s5_busy_during", 64'(busy), 64'd1);
        waitValid("s5", LAT_MAX - 150);
        @(negedge clk);
        checkOutput("s5_busy_after", 64'(busy), 64'd0);
        repeat (600) @(negedge clk);
        checkOutput("s5_valid_pulses", 64'(valid_count - vc_before), 64'd1);

        // 6: reset during class 4 aborts at once; a fresh run then reproduces scenario 1.
        vc_before = valid_count;
        startRun({NUM_IN{1'b1}});
        for (int i = 0; i < LAT_MAX; i++) begin
            @(negedge clk);
            if (b_addr == 4'd4) break;
        end
        checkOutput("s6_reached_class4", 64'(b_addr), 64'd4);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("s6_abort_neu_start", 64'(neu_start), 64'd0);
        checkOutput("s6_abort_busy", 64'(busy), 64'd0);
        checkOutput("s6_abort_logits", 64'(logits), 64'd0);
        checkOutput("s6_abort_class_score", 64'(class_score), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("s6_no_valid_aborted", 64'(valid_count - vc_before), 64'd0);
        applyStimulus("s6", {NUM_IN{1'b1}}, l_exp, 4'd7, 6'd22);

        repeat (5) @(negedge clk);
        checkOutput("pending_expectations", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
